// File: rtl/shift_cnt_pkg.sv
// Shared encodings for the shift/ring counter family.
package shift_cnt_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_LSB      = 1'b0;
   localparam logic DIR_MSB      = 1'b1;

endpackage

// File: rtl/shift_cnt_legal_chk.sv
// Combinational legality decode of a ring (one-hot) or Johnson counter state.
module shift_cnt_legal_chk
   import shift_cnt_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic             mode,
   output logic             legal
);

   int unsigned ones;
   int unsigned edges;

   // Johnson states have at most one boundary between a run of ones and a run of zeros
   always_comb begin
      ones  = 0;
      edges = 0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         ones = ones + 32'(q[i]);
      end
      for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
         edges = edges + 32'(q[i] ^ q[i+1]);
      end
      if (mode == MODE_JOHNSON) legal = (edges <= 1);
      else                      legal = (ones == 1);
   end

endmodule

// File: rtl/shift_ring_counter.sv
// Ring / Johnson shift counter with enable, direction, parallel load, wrap pulse and
// illegal-state detection with optional reseed.
module shift_ring_counter
   import shift_cnt_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter bit          SELF_CORRECT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             illegal,
   output logic             illegal_sticky
);

   localparam logic [WIDTH-1:0] SEED_RING = WIDTH'(1);
   localparam logic [WIDTH-1:0] SEED_JOHN = '0;

   function automatic logic [WIDTH-1:0] seed(input logic m);
      return (m == MODE_JOHNSON) ? SEED_JOHN : SEED_RING;
   endfunction

   logic             mode_q;
   logic             legal;
   logic             fb;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] q_nxt;
   logic             mode_nxt;
   logic             tc_nxt;

   shift_cnt_legal_chk #(.WIDTH(WIDTH)) u_legal (
      .q     (q),
      .mode  (mode_q),
      .legal (legal)
   );

   assign illegal = ~legal;

   always_comb begin
      fb      = 1'b0;
      shifted = q;
      if (dir == DIR_MSB) begin
         fb      = (mode_q == MODE_JOHNSON) ? ~q[WIDTH-1] : q[WIDTH-1];
         shifted = {q[WIDTH-2:0], fb};
      end else begin
         fb      = (mode_q == MODE_JOHNSON) ? ~q[0] : q[0];
         shifted = {fb, q[WIDTH-1:1]};
      end
   end

   // tc only follows a plain shift; every other transition clears it
   always_comb begin
      q_nxt    = q;
      mode_nxt = mode_q;
      tc_nxt   = 1'b0;
      if (load) begin
         q_nxt    = load_val;
         mode_nxt = mode;
      end else if (mode != mode_q) begin
         q_nxt    = seed(mode);
         mode_nxt = mode;
      end else if (en && illegal && SELF_CORRECT) begin
         q_nxt = seed(mode_q);
      end else if (en) begin
         q_nxt  = shifted;
         tc_nxt = (shifted == seed(mode_q));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q         <= mode;
         q              <= seed(mode);
         tc             <= 1'b0;
         illegal_sticky <= 1'b0;
      end else begin
         mode_q         <= mode_nxt;
         q              <= q_nxt;
         tc             <= tc_nxt;
         illegal_sticky <= illegal_sticky | illegal;
      end
   end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Directed bench: WIDTH=4 self-correcting instance plus WIDTH=6 non-correcting instance.
module tb_shift_ring_counter;

   logic       clk = 1'b0;
   logic       rst, en, mode, dir, load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc, illegal, illegal_sticky;

   logic       rst6, en6, mode6, dir6, load6;
   logic [5:0] load_val6;
   logic [5:0] q6;
   logic       tc6, illegal6, illegal_sticky6;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   shift_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .illegal(illegal),
      .illegal_sticky(illegal_sticky)
   );

   shift_ring_counter #(.WIDTH(6), .SELF_CORRECT(1'b0)) dut6 (
      .clk(clk), .rst(rst6), .en(en6), .mode(mode6), .dir(dir6), .load(load6),
      .load_val(load_val6), .q(q6), .tc(tc6), .illegal(illegal6),
      .illegal_sticky(illegal_sticky6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] ring_exp [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                4'b1000, 4'b0100, 4'b0010, 4'b0001};
   logic       ring_tc  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
   logic [3:0] john_exp [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};
   logic [5:0] j6_exp   [4] = '{6'b110100, 6'b111010, 6'b111101, 6'b011110};

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
      rst6 = 1'b1; en6 = 1'b0; mode6 = 1'b1; dir6 = 1'b0; load6 = 1'b0; load_val6 = '0;
      #1;
      step();
      chk("rst_q", 32'(q), 32'(4'b0001));
      chk("rst_tc", 32'(tc), 0);
      chk("rst_sticky", 32'(illegal_sticky), 0);
      chk("rst_illegal", 32'(illegal), 0);

      // ring, dir toward LSB
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("ring_q", 32'(q), 32'(ring_exp[i]));
         chk("ring_tc", 32'(tc), 32'(ring_tc[i]));
      end

      // johnson, dir toward LSB
      rst = 1'b1; mode = 1'b1;
      step();
      chk("john_rst_q", 32'(q), 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("john_q", 32'(q), 32'(john_exp[i]));
         chk("john_tc", 32'(tc), (i == 7) ? 1 : 0);
         chk("john_illegal", 32'(illegal), 0);
      end

      // ring, dir toward MSB, flip, then hold
      rst = 1'b1; mode = 1'b0; en = 1'b0;
      step();
      rst = 1'b0; en = 1'b1; dir = 1'b1;
      step(); chk("msb_q1", 32'(q), 32'(4'b0010));
      step(); chk("msb_q2", 32'(q), 32'(4'b0100));
      dir = 1'b0;
      step(); chk("flip_q", 32'(q), 32'(4'b0010));
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_q", 32'(q), 32'(4'b0010));
         chk("hold_tc", 32'(tc), 0);
      end

      // illegal load with self-correct
      load = 1'b1; load_val = 4'b0101;
      step();
      load = 1'b0;
      chk("ld_q", 32'(q), 32'(4'b0101));
      chk("ld_illegal", 32'(illegal), 1);
      chk("ld_tc", 32'(tc), 0);
      en = 1'b1;
      step();
      chk("sc_q", 32'(q), 32'(4'b0001));
      chk("sc_tc", 32'(tc), 0);
      chk("sc_sticky", 32'(illegal_sticky), 1);
      chk("sc_illegal", 32'(illegal), 0);
      step(); step();
      chk("sc_q2", 32'(q), 32'(4'b0100));
      chk("sticky_keep", 32'(illegal_sticky), 1);

      // mode switch ring -> johnson with en high
      mode = 1'b1;
      step();
      chk("sw_q", 32'(q), 0);
      chk("sw_tc", 32'(tc), 0);
      step();
      chk("sw_q2", 32'(q), 32'(4'b1000));
      chk("sw_tc2", 32'(tc), 0);
      rst = 1'b1;
      step();
      chk("rst_sticky_clr", 32'(illegal_sticky), 0);
      rst = 1'b0; en = 1'b0;

      // WIDTH=6 johnson, no self-correct
      step();
      rst6 = 1'b0;
      chk("w6_rst_q", 32'(q6), 0);
      load6 = 1'b1; load_val6 = 6'b101000;
      step();
      load6 = 1'b0; en6 = 1'b1;
      chk("w6_ld_q", 32'(q6), 32'(6'b101000));
      chk("w6_ld_illegal", 32'(illegal6), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("w6_q", 32'(q6), 32'(j6_exp[i]));
         chk("w6_illegal", 32'(illegal6), 1);
         chk("w6_tc", 32'(tc6), 0);
      end
      chk("w6_sticky", 32'(illegal_sticky6), 1);
      rst6 = 1'b1; load6 = 1'b1; load_val6 = 6'b111111;
      step();
      rst6 = 1'b0; load6 = 1'b0; en6 = 1'b0;
      chk("w6_rstld_q", 32'(q6), 0);
      chk("w6_rstld_sticky", 32'(illegal_sticky6), 0);
      chk("w6_rstld_tc", 32'(tc6), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
